// File: rtl/wb_mem_ws.sv
// Wishbone classic slave backed by an inferred byte-lane RAM, with a fixed
// number of wait states per transfer and error termination above DEPTH.
module wb_mem_ws #(
    parameter int DW    = 16,
    parameter int AW    = 15,
    parameter int DEPTH = 2**AW,
    parameter int WAIT  = 0
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            cyc_i,
    input  logic            stb_i,
    input  logic            we_i,
    input  logic [DW/8-1:0] sel_i,
    input  logic [AW-1:0]   adr_i,
    input  logic [DW-1:0]   dat_i,
    output logic            ack_o,
    output logic            err_o,
    output logic [DW-1:0]   dat_o
);

    localparam int NB = DW / 8;
    localparam int MW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] WAIT_M1 = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [3:0]      r_cnt;
    logic [AW-1:0]   r_adr;
    logic            r_we;
    logic [NB-1:0]   r_sel;
    logic [DW-1:0]   r_dat;
    logic            r_ack;
    logic            r_err;
    logic [DW-1:0]   r_rdata;
    logic [DW-1:0]   r_mem [DEPTH];

    logic            w_req;
    logic [AW-1:0]   w_adr;
    logic            w_we;
    logic [NB-1:0]   w_sel;
    logic [DW-1:0]   w_dat;
    logic            w_oor;
    logic [MW-1:0]   w_idx;
    logic            w_go_resp;
    logic            w_ack_nxt;
    logic            w_err_nxt;
    logic            w_wr;
    logic            w_rd;

    assign w_req = cyc_i & stb_i;

    // With zero wait states the transfer completes on the same edge it is
    // latched, so IDLE must act on the live bus rather than the latches.
    assign w_adr = (r_state == S_IDLE) ? adr_i : r_adr;
    assign w_we  = (r_state == S_IDLE) ? we_i  : r_we;
    assign w_sel = (r_state == S_IDLE) ? sel_i : r_sel;
    assign w_dat = (r_state == S_IDLE) ? dat_i : r_dat;
    assign w_oor = (32'(w_adr) >= 32'(DEPTH));
    assign w_idx = w_adr[MW-1:0];

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    w_state_nxt = (WAIT == 0 || w_oor) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (!cyc_i) begin
                    w_state_nxt = S_IDLE;
                end else if (r_cnt == 4'd0) begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_go_resp = rst_i && (r_state != S_RESP) && (w_state_nxt == S_RESP);
        w_ack_nxt = w_go_resp && !w_oor;
        w_err_nxt = w_go_resp && w_oor;
        w_wr      = w_ack_nxt && w_we;
        w_rd      = w_ack_nxt && !w_we;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_adr   <= '0;
            r_we    <= 1'b0;
            r_sel   <= '0;
            r_dat   <= '0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ack   <= w_ack_nxt;
            r_err   <= w_err_nxt;
            if (r_state == S_IDLE && w_req) begin
                r_adr <= adr_i;
                r_we  <= we_i;
                r_sel <= sel_i;
                r_dat <= dat_i;
            end
            if (r_state == S_IDLE && w_state_nxt == S_WAIT) begin
                r_cnt <= WAIT_M1;
            end else if (r_state == S_WAIT && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_rd) begin
                r_rdata <= r_mem[w_idx];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_wr) begin
            for (int b = 0; b < NB; b++) begin
                if (w_sel[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_dat[8*b +: 8];
                end
            end
        end
    end

    assign ack_o = r_ack;
    assign err_o = r_err;
    assign dat_o = r_rdata;

endmodule

// File: tb/tb_wb_mem_ws.sv
// Directed bench for wb_mem_ws at DW=16, AW=15, DEPTH=1024, WAIT=2.
module tb_wb_mem_ws;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        cyc_i;
    logic        stb_i;
    logic        we_i;
    logic [1:0]  sel_i;
    logic [14:0] adr_i;
    logic [15:0] dat_i;
    logic        ack_o;
    logic        err_o;
    logic [15:0] dat_o;

    int n_chk  = 0;
    int n_pass = 0;

    int ack_n, ack_at, err_n, err_at;
    int acks [$];

    wb_mem_ws #(.DW(16), .AW(15), .DEPTH(1024), .WAIT(2)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .cyc_i (cyc_i),
        .stb_i (stb_i),
        .we_i  (we_i),
        .sel_i (sel_i),
        .adr_i (adr_i),
        .dat_i (dat_i),
        .ack_o (ack_o),
        .err_o (err_o),
        .dat_o (dat_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // One transfer: request is live for edge E0 only; afterwards the bus
    // inputs are scrambled, stb drops and cyc stays high unless aborting.
    // Terminations are logged by negedge index k (cycle after edge E0+k).
    task automatic xfer(input logic we, input logic [1:0] sel, input logic [14:0] adr,
                        input logic [15:0] dat, input logic abort,
                        output int a_n, output int a_at, output int e_n, output int e_at);
        @(negedge clk_i);
        cyc_i = 1'b1; stb_i = 1'b1; we_i = we; sel_i = sel; adr_i = adr; dat_i = dat;
        @(posedge clk_i);
        #1;
        stb_i = 1'b0; cyc_i = !abort;
        we_i = ~we; sel_i = ~sel; adr_i = ~adr; dat_i = ~dat;
        a_n = 0; a_at = -1; e_n = 0; e_at = -1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk_i);
            if (ack_o) begin a_n++; if (a_at < 0) a_at = k; end
            if (err_o) begin e_n++; if (e_at < 0) e_at = k; end
        end
        cyc_i = 1'b0; we_i = 1'b0; sel_i = 2'b00; adr_i = '0; dat_i = '0;
    endtask

    initial begin
        rst_i = 1'b0; cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
        sel_i = 2'b00; adr_i = '0; dat_i = '0;
        repeat (2) @(negedge clk_i);
        check("rst_ack", ack_o, 0);
        check("rst_err", err_o, 0);
        check("rst_dat", dat_o, 0);

        // Request held during reset must be ignored
        cyc_i = 1'b1; stb_i = 1'b1; adr_i = 15'h010;
        ack_n = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk_i);
            if (ack_o || err_o) ack_n++;
        end
        check("rst_req_ignored", ack_n, 0);
        cyc_i = 1'b0; stb_i = 1'b0; adr_i = '0;
        rst_i = 1'b1;
        @(negedge clk_i);

        // Full write then read back
        xfer(1'b1, 2'b11, 15'h010, 16'hBEEF, 1'b0, ack_n, ack_at, err_n, err_at);
        check("wr_beef_ack_n", ack_n, 1);
        check("wr_beef_ack_at", ack_at, 2);
        check("wr_beef_err_n", err_n, 0);
        xfer(1'b0, 2'b11, 15'h010, 16'h0000, 1'b0, ack_n, ack_at, err_n, err_at);
        check("rd_beef_ack_n", ack_n, 1);
        check("rd_beef_ack_at", ack_at, 2);
        check("rd_beef_dat", dat_o, 16'hBEEF);

        // Low lane only
        xfer(1'b1, 2'b01, 15'h010, 16'h1234, 1'b0, ack_n, ack_at, err_n, err_at);
        check("wr_lo_ack_n", ack_n, 1);
        xfer(1'b0, 2'b00, 15'h010, 16'h0000, 1'b0, ack_n, ack_at, err_n, err_at);
        check("rd_be34_ack_n", ack_n, 1);
        check("rd_be34_dat", dat_o, 16'hBE34);

        // High lane only
        xfer(1'b1, 2'b10, 15'h011, 16'hFFFF, 1'b0, ack_n, ack_at, err_n, err_at);
        xfer(1'b1, 2'b10, 15'h011, 16'h7A00, 1'b0, ack_n, ack_at, err_n, err_at);
        xfer(1'b0, 2'b11, 15'h011, 16'h0000, 1'b0, ack_n, ack_at, err_n, err_at);
        check("rd_hi_lane_dat", dat_o & 16'hFF00, 16'h7A00);

        // sel = 0 write: ack but no change
        xfer(1'b1, 2'b00, 15'h010, 16'h0000, 1'b0, ack_n, ack_at, err_n, err_at);
        check("wr_sel0_ack_n", ack_n, 1);
        xfer(1'b0, 2'b11, 15'h010, 16'h0000, 1'b0, ack_n, ack_at, err_n, err_at);
        check("wr_sel0_dat", dat_o, 16'hBE34);

        // Out-of-range write aliases to 0x000 if not blocked
        xfer(1'b1, 2'b11, 15'h000, 16'hA5A5, 1'b0, ack_n, ack_at, err_n, err_at);
        xfer(1'b1, 2'b11, 15'h400, 16'h7777, 1'b0, ack_n, ack_at, err_n, err_at);
        check("oor_err_n", err_n, 1);
        check("oor_err_at", err_at, 0);
        check("oor_ack_n", ack_n, 0);
        check("oor_dat_hold", dat_o, 16'hBE34);
        xfer(1'b0, 2'b11, 15'h400, 16'h0000, 1'b0, ack_n, ack_at, err_n, err_at);
        check("oor_rd_err_n", err_n, 1);
        check("oor_rd_dat_hold", dat_o, 16'hBE34);
        xfer(1'b0, 2'b11, 15'h000, 16'h0000, 1'b0, ack_n, ack_at, err_n, err_at);
        check("oor_alias_dat", dat_o, 16'hA5A5);

        // Abort by dropping cyc during WAIT
        xfer(1'b1, 2'b11, 15'h020, 16'h1111, 1'b0, ack_n, ack_at, err_n, err_at);
        xfer(1'b1, 2'b11, 15'h020, 16'h5555, 1'b1, ack_n, ack_at, err_n, err_at);
        check("abort_ack_n", ack_n, 0);
        check("abort_err_n", err_n, 0);
        xfer(1'b0, 2'b11, 15'h020, 16'h0000, 1'b0, ack_n, ack_at, err_n, err_at);
        check("abort_rd_dat", dat_o, 16'h1111);

        // Reset asserted while a write to 0x030 is waiting
        xfer(1'b1, 2'b11, 15'h030, 16'h3333, 1'b0, ack_n, ack_at, err_n, err_at);
        xfer(1'b0, 2'b11, 15'h030, 16'h0000, 1'b0, ack_n, ack_at, err_n, err_at);
        check("pre_rst_dat", dat_o, 16'h3333);
        @(negedge clk_i);
        cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1; sel_i = 2'b11; adr_i = 15'h030; dat_i = 16'h9999;
        @(posedge clk_i);
        #1;
        stb_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        check("wrst_ack", ack_o, 0);
        check("wrst_dat", dat_o, 0);
        rst_i = 1'b1;
        ack_n = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk_i);
            if (ack_o || err_o) ack_n++;
        end
        check("wrst_no_term", ack_n, 0);
        cyc_i = 1'b0; we_i = 1'b0; adr_i = '0; dat_i = '0; sel_i = 2'b00;
        xfer(1'b0, 2'b11, 15'h030, 16'h0000, 1'b0, ack_n, ack_at, err_n, err_at);
        check("wrst_idle_ack_at", ack_at, 2);
        check("wrst_mem_hold", dat_o, 16'h3333);

        // Back-to-back reads with cyc/stb held
        @(negedge clk_i);
        cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; sel_i = 2'b11; adr_i = 15'h010;
        @(posedge clk_i);
        for (int k = 0; k < 12; k++) begin
            @(negedge clk_i);
            if (ack_o) acks.push_back(k);
        end
        cyc_i = 1'b0; stb_i = 1'b0;
        check("b2b_count", acks.size(), 3);
        if (acks.size() == 3) begin
            check("b2b_first", acks[0], 2);
            check("b2b_gap1", acks[1] - acks[0], 4);
            check("b2b_gap2", acks[2] - acks[1], 4);
        end
        check("b2b_dat", dat_o, 16'hBE34);

        repeat (3) @(negedge clk_i);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
